// File: rtl/lbus_regmap_param_if.sv
// Local-bus interface between the SPI slave (master side) and the register map
// (slave side). Strobes, address and write data live in the sclk domain, and
// the read data returns registered in the clk domain.
interface lbus_regmap_param_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              rd_en_sclk;
    logic              wr_en_sclk;
    logic [ADDR_W-1:0] address_sclk;
    logic [DATA_W-1:0] wdata_sclk;
    logic [DATA_W-1:0] rdata;

    modport master (
        output rd_en_sclk,
        output wr_en_sclk,
        output address_sclk,
        output wdata_sclk,
        input  rdata
    );

    modport slave (
        input  rd_en_sclk,
        input  wr_en_sclk,
        input  address_sclk,
        input  wdata_sclk,
        output rdata
    );
endinterface

// File: rtl/lbus_regmap_param.sv
// Parametrised local-bus register map behind the SPI slave.
// The strobes are synchronised into clk with an edge detect. A window of RW
// control registers and RO status registers is decoded, with per-register write
// pulses and a saturating access-error counter.
// Optional feature: define REGMAP_WRITE_LOCK_EN to make offset 0 a lock register.
// Offsets 1..NUM_RW-1 are then writable only while reg0 holds 8'hA5.
module lbus_regmap_param #(
    parameter int                       ADDR_W    = 16,
    parameter int                       DATA_W    = 8,
    parameter int                       NUM_RW    = 8,
    parameter int                       NUM_RO    = 4,
    parameter logic [ADDR_W-1:0]        BASE_ADDR = '0,
    parameter logic [NUM_RW*DATA_W-1:0] RESET_VAL = '0,
    parameter logic [DATA_W-1:0]        ERR_RDATA = DATA_W'(8'hEE)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    lbus_regmap_param_if.slave                           bus,
    input  logic [(NUM_RO > 0 ? NUM_RO*DATA_W : 1)-1:0]  status_in,
    output logic [NUM_RW*DATA_W-1:0]                     regs_out,
    output logic [NUM_RW-1:0]                            wr_pulse,
    output logic [7:0]                                   err_count
);

    localparam logic [ADDR_W-1:0] NUM_RW_A = ADDR_W'(NUM_RW);
    localparam logic [ADDR_W-1:0] TOTAL_A  = ADDR_W'(NUM_RW + NUM_RO);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_ERR,
        ST_WAIT
    } state_t;

    state_t state, state_next;

    logic rd_meta, rd_s, rd_d;
    logic wr_meta, wr_s, wr_d;
    logic rd_edge, wr_edge;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic              is_rw;
    logic              write_ok;
    logic              commit;
    logic [DATA_W-1:0] read_val;

    logic [DATA_W-1:0] regs [NUM_RW];

    // Two-flop synchronisers plus a delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_meta <= 1'b0;
            rd_s    <= 1'b0;
            rd_d    <= 1'b0;
            wr_meta <= 1'b0;
            wr_s    <= 1'b0;
            wr_d    <= 1'b0;
        end else begin
            rd_meta <= bus.rd_en_sclk;
            rd_s    <= rd_meta;
            rd_d    <= rd_s;
            wr_meta <= bus.wr_en_sclk;
            wr_s    <= wr_meta;
            wr_d    <= wr_s;
        end
    end

    assign rd_edge = rd_s & ~rd_d;
    assign wr_edge = wr_s & ~wr_d;

    assign offset   = addr_q - BASE_ADDR;
    assign in_range = offset < TOTAL_A;
    assign is_rw    = offset < NUM_RW_A;

`ifdef REGMAP_WRITE_LOCK_EN
    assign write_ok = (offset == '0) || (regs[0] == DATA_W'(8'hA5));
`else
    assign write_ok = 1'b1;
`endif

    assign commit = (state == ST_WRITE) && is_rw && write_ok;

    // Read mux: RW registers, then RO status slices, else the error pattern
    always_comb begin
        read_val = ERR_RDATA;
        for (int i = 0; i < NUM_RW; i++) begin
            if (offset == ADDR_W'(i)) read_val = regs[i];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (offset == ADDR_W'(NUM_RW + j)) read_val = status_in[j*DATA_W +: DATA_W];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; WAIT holds off new accesses until both strobes are low
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rd_edge && wr_edge) state_next = ST_ERR;
                else if (rd_edge)       state_next = ST_READ;
                else if (wr_edge)       state_next = ST_WRITE;
            end
            ST_READ:  state_next = in_range ? ST_WAIT : ST_ERR;
            ST_WRITE: state_next = commit ? ST_WAIT : ST_ERR;
            ST_ERR:   state_next = ST_WAIT;
            ST_WAIT:  if (!rd_s && !wr_s) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: address/data capture on the detected edge, read data, register writes, error count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            bus.rdata <= '0;
            wr_pulse  <= '0;
            err_count <= 8'd0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
            end
        end else begin
            wr_pulse <= '0;
            if (state == ST_IDLE && (rd_edge || wr_edge)) begin
                addr_q  <= bus.address_sclk;
                wdata_q <= bus.wdata_sclk;
            end
            if (state == ST_READ) begin
                bus.rdata <= read_val;
            end
            if (commit) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (offset == ADDR_W'(i)) begin
                        regs[i]     <= wdata_q;
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
            if (state == ST_ERR && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_lbus_regmap_param.sv
// Directed self-checking bench for lbus_regmap_param using the default 8+4 register window.
module tb_lbus_regmap_param;

    localparam logic [63:0] RST_IMG = 64'h8877_6655_4433_2211;
    localparam logic [31:0] STATUS  = 32'h1122_3344;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status_in;
    logic [63:0] regs_out;
    logic [7:0]  wr_pulse;
    logic [7:0]  err_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_regs [8];
    int         exp_err;
    logic [7:0] exp_rdata;

    lbus_regmap_param_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    lbus_regmap_param #(
        .ADDR_W(16), .DATA_W(8), .NUM_RW(8), .NUM_RO(4),
        .BASE_ADDR(16'h0000), .RESET_VAL(RST_IMG), .ERR_RDATA(8'hEE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .status_in(status_in),
        .regs_out(regs_out),
        .wr_pulse(wr_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Safety net so a broken design can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic raise(input bit rd, input bit wr, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.address_sclk = a;
        bus.wdata_sclk   = d;
        bus.rd_en_sclk   = rd;
        bus.wr_en_sclk   = wr;
    endtask

    task automatic release_bus();
        bus.rd_en_sclk = 1'b0;
        bus.wr_en_sclk = 1'b0;
        step(6);
    endtask

    function automatic logic [63:0] model_image();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = exp_regs[i];
        return v;
    endfunction

    task automatic load_reset_model();
        for (int i = 0; i < 8; i++) exp_regs[i] = RST_IMG[i*8 +: 8];
        exp_err   = 0;
        exp_rdata = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        load_reset_model();
        vectors++;
        if (regs_out !== RST_IMG) begin
            miscompares++;
            $display("[TB] FAIL reset_regs: got %h expected %h", regs_out, RST_IMG);
        end
        vectors++;
        if (wr_pulse !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_pulse: got %h expected 00", wr_pulse);
        end
        vectors++;
        if (err_count !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_err: got %h expected 00", err_count);
        end
        vectors++;
        if (bus.rdata !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected 00", bus.rdata);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_read_all();
        logic [7:0] want;
        for (int off = 0; off < 12; off++) begin
            want = (off < 8) ? exp_regs[off] : STATUS[(off-8)*8 +: 8];
            raise(1'b1, 1'b0, 16'(off), 8'h00);
            step(3);
            vectors++;
            if (bus.rdata !== exp_rdata) begin
                miscompares++;
                $display("[TB] FAIL read_early off=%0d: got %h expected %h", off, bus.rdata, exp_rdata);
            end
            step(1);
            exp_rdata = want;
            vectors++;
            if (bus.rdata !== want) begin
                miscompares++;
                $display("[TB] FAIL read_all off=%0d: got %h expected %h", off, bus.rdata, want);
            end
            release_bus();
        end
        vectors++;
        if (err_count !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL read_all_err: got %h expected 00", err_count);
        end
    endtask

    task automatic test_offset2_write();
`ifdef REGMAP_WRITE_LOCK_EN
        raise(1'b0, 1'b1, 16'h0002, 8'h77);
        step(4);
        vectors++;
        if (wr_pulse !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL locked_pulse: got %h expected 00", wr_pulse);
        end
        step(1);
        exp_err++;
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("[TB] FAIL locked_err: got %h expected %h", err_count, 8'(exp_err));
        end
        release_bus();
        vectors++;
        if (regs_out !== model_image()) begin
            miscompares++;
            $display("[TB] FAIL locked_regs: got %h expected %h", regs_out, model_image());
        end
        raise(1'b0, 1'b1, 16'h0000, 8'hA5);
        step(4);
        exp_regs[0] = 8'hA5;
        vectors++;
        if (regs_out[7:0] !== 8'hA5 || wr_pulse !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL unlock: got reg0=%h pulse=%h expected reg0=a5 pulse=01", regs_out[7:0], wr_pulse);
        end
        release_bus();
`endif
        raise(1'b0, 1'b1, 16'h0002, 8'h77);
        step(4);
        exp_regs[2] = 8'h77;
        vectors++;
        if (regs_out[23:16] !== 8'h77 || wr_pulse !== 8'h04) begin
            miscompares++;
            $display("[TB] FAIL write_off2: got byte2=%h pulse=%h expected byte2=77 pulse=04", regs_out[23:16], wr_pulse);
        end
        step(1);
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("[TB] FAIL write_off2_err: got %h expected %h", err_count, 8'(exp_err));
        end
        release_bus();
    endtask

    task automatic test_write();
        raise(1'b0, 1'b1, 16'h0003, 8'h5A);
        step(3);
        vectors++;
        if (regs_out[31:24] !== exp_regs[3] || wr_pulse !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL write_early: got byte3=%h pulse=%h expected byte3=%h pulse=00", regs_out[31:24], wr_pulse, exp_regs[3]);
        end
        step(1);
        exp_regs[3] = 8'h5A;
        vectors++;
        if (regs_out[31:24] !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL write_data: got %h expected 5a", regs_out[31:24]);
        end
        vectors++;
        if (wr_pulse !== 8'b0000_1000) begin
            miscompares++;
            $display("[TB] FAIL write_pulse: got %b expected 00001000", wr_pulse);
        end
        step(1);
        vectors++;
        if (wr_pulse !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL write_pulse_len: got %b expected 00000000", wr_pulse);
        end
        release_bus();
        vectors++;
        if (regs_out !== model_image()) begin
            miscompares++;
            $display("[TB] FAIL write_image: got %h expected %h", regs_out, model_image());
        end
    endtask

    task automatic test_read_status();
        raise(1'b1, 1'b0, 16'h0009, 8'h00);
        step(4);
        exp_rdata = 8'h33;
        vectors++;
        if (bus.rdata !== 8'h33) begin
            miscompares++;
            $display("[TB] FAIL read_ro1: got %h expected 33", bus.rdata);
        end
        release_bus();
        raise(1'b1, 1'b0, 16'h0040, 8'h00);
        step(4);
        exp_rdata = 8'hEE;
        vectors++;
        if (bus.rdata !== 8'hEE || err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("[TB] FAIL read_oob: got rdata=%h err=%h expected rdata=ee err=%h", bus.rdata, err_count, 8'(exp_err));
        end
        step(1);
        exp_err++;
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("[TB] FAIL read_oob_err: got %h expected %h", err_count, 8'(exp_err));
        end
        release_bus();
    endtask

    task automatic test_errors();
        raise(1'b0, 1'b1, 16'h0008, 8'hCC);
        step(4);
        vectors++;
        if (wr_pulse !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL ro_write_pulse: got %h expected 00", wr_pulse);
        end
        step(1);
        exp_err++;
        vectors++;
        if (err_count !== 8'(exp_err)) begin
            miscompares++;
            $display("[TB] FAIL ro_write_err: got %h expected %h", err_count, 8'(exp_err));
        end
        release_bus();
        vectors++;
        if (regs_out !== model_image()) begin
            miscompares++;
            $display("[TB] FAIL ro_write_regs: got %h expected %h", regs_out, model_image());
        end
        raise(1'b1, 1'b1, 16'h0001, 8'h99);
        step(4);
        exp_err++;
        vectors++;
        if (err_count !== 8'(exp_err) || bus.rdata !== exp_rdata) begin
            miscompares++;
            $display("[TB] FAIL both_edges: got err=%h rdata=%h expected err=%h rdata=%h", err_count, bus.rdata, 8'(exp_err), exp_rdata);
        end
        release_bus();
        vectors++;
        if (regs_out !== model_image()) begin
            miscompares++;
            $display("[TB] FAIL both_edges_regs: got %h expected %h", regs_out, model_image());
        end
        for (int n = 0; n < 300; n++) begin
            raise(1'b1, 1'b0, 16'h0040, 8'h00);
            step(5);
            if (exp_err < 255) exp_err++;
            vectors++;
            if (err_count !== 8'(exp_err)) begin
                miscompares++;
                $display("[TB] FAIL err_sat n=%0d: got %h expected %h", n, err_count, 8'(exp_err));
            end
            release_bus();
        end
        vectors++;
        if (err_count !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL err_final: got %h expected ff", err_count);
        end
    endtask

    task automatic test_mid_reset();
        raise(1'b0, 1'b1, 16'h0001, 8'h99);
        step(2);
        rst_n          = 1'b0;
        bus.wr_en_sclk = 1'b0;
        step(1);
        rst_n = 1'b1;
        load_reset_model();
        step(8);
        vectors++;
        if (regs_out !== RST_IMG) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_regs: got %h expected %h", regs_out, RST_IMG);
        end
        vectors++;
        if (err_count !== 8'h00 || wr_pulse !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_state: got err=%h pulse=%h expected err=00 pulse=00", err_count, wr_pulse);
        end
    endtask

    initial begin
        rst_n            = 1'b1;
        status_in        = STATUS;
        bus.rd_en_sclk   = 1'b0;
        bus.wr_en_sclk   = 1'b0;
        bus.address_sclk = 16'h0000;
        bus.wdata_sclk   = 8'h00;
        load_reset_model();
        test_reset();
        test_read_all();
        test_offset2_write();
        test_write();
        test_read_status();
        test_errors();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
